seq_shift_unit: RTL and testbench

//  Multi-cycle, parametrised shift unit for the CPU datapath; successor to the fixed

---
 rtl/seq_shift_pkg.sv | 15 +
 rtl/shift_step.sv | 36 +++
 rtl/seq_shift_unit.sv | 113 +++++++++++
 tb/tb_seq_shift_unit.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/seq_shift_pkg.sv
// Shared encodings for the sequential shift unit: operation codes and FSM states.
package seq_shift_pkg;

   localparam logic [1:0] OP_SLL = 2'b00;
   localparam logic [1:0] OP_SRL = 2'b01;
   localparam logic [1:0] OP_SRA = 2'b10;
   localparam logic [1:0] OP_ROR = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_DONE  = 2'b10
   } state_t;

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shifter: moves a WIDTH-bit value by k (0..STEP) bits.
// Rotate logic exists only when SEQ_SHIFT_ROTATE_EN is defined.
module shift_step
   import seq_shift_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int K_W   = 1
) (
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] val,
   input  logic [K_W-1:0]   k,
   output logic [WIDTH-1:0] res
);

`ifdef SEQ_SHIFT_ROTATE_EN
   localparam int ROT_W = $clog2(WIDTH) + 1;
`endif

   always_comb begin
      res = val;
      case (op)
         OP_SLL:  res = val << k;
         OP_SRL:  res = val >> k;
         OP_SRA:  res = $signed(val) >>> k;
         default: begin
`ifdef SEQ_SHIFT_ROTATE_EN
            // k=0 makes the left term shift by WIDTH, which yields zero as needed.
            res = (val >> k) | (val << (ROT_W'(WIDTH) - ROT_W'(k)));
`else
            res = val;
`endif
         end
      endcase
   end

endmodule

// File: rtl/seq_shift_unit.sv
// Multi-cycle SLL/SRL/SRA shifter, STEP bits per clock, start/busy/done handshake.
// Optional rotate-right on op=11 when SEQ_SHIFT_ROTATE_EN is defined.
module seq_shift_unit
   import seq_shift_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int STEP    = 1,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [1:0]         op,
   input  logic [WIDTH-1:0]   din,
   input  logic [SHAMT_W-1:0] shamt,
   output logic               busy,
   output logic               done,
   output logic [WIDTH-1:0]   dout,
   output logic [1:0]         state_dbg
);

   // Handshake: a request is taken on a rising edge where start=1 and busy=0;
   // done pulses for exactly one cycle with dout valid, and dout holds afterwards.

   localparam int               K_W    = $clog2(STEP + 1);
   localparam logic [SHAMT_W:0] STEP_W = (SHAMT_W + 1)'(STEP);

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     work_q, work_d;
   logic [WIDTH-1:0]     dout_q, dout_d;
   logic [SHAMT_W-1:0]   rem_q, rem_d;
   logic [1:0]           op_q, op_d;
   logic [SHAMT_W:0]     k_full;
   logic [K_W-1:0]       k;
   logic [WIDTH-1:0]     shifted;
   logic                 op_noop;
   logic [SHAMT_W-1:0]   eff_shamt;

`ifdef SEQ_SHIFT_ROTATE_EN
   assign op_noop = 1'b0;
`else
   assign op_noop = (op == OP_ROR);
`endif
   assign eff_shamt = op_noop ? '0 : shamt;

   assign k_full = ({1'b0, rem_q} > STEP_W) ? STEP_W : {1'b0, rem_q};
   assign k      = k_full[K_W-1:0];

   shift_step #(
      .WIDTH (WIDTH),
      .K_W   (K_W)
   ) u_step (
      .op  (op_q),
      .val (work_q),
      .k   (k),
      .res (shifted)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (start) state_d = (eff_shamt != '0) ? ST_SHIFT : ST_DONE;
         ST_SHIFT: state_d = ({1'b0, rem_q} > STEP_W) ? ST_SHIFT : ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      busy      = (state_q != ST_IDLE);
      done      = (state_q == ST_DONE);
      state_dbg = state_q;
   end

   // dout is loaded on entry to DONE so it is already valid during the done pulse.
   always_comb begin
      work_d = work_q;
      rem_d  = rem_q;
      op_d   = op_q;
      dout_d = dout_q;
      if (state_q == ST_IDLE && start) begin
         work_d = din;
         rem_d  = eff_shamt;
         op_d   = op;
      end else if (state_q == ST_SHIFT) begin
         work_d = shifted;
         rem_d  = rem_q - k_full[SHAMT_W-1:0];
      end
      if (state_d == ST_DONE) dout_d = work_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         work_q <= '0;
         rem_q  <= '0;
         op_q   <= '0;
         dout_q <= '0;
      end else begin
         work_q <= work_d;
         rem_q  <= rem_d;
         op_q   <= op_d;
         dout_q <= dout_d;
      end
   end

   assign dout = dout_q;

endmodule

// File: tb/tb_seq_shift_unit.sv
// Bench for seq_shift_unit: STEP=1 and STEP=4 instances share stimulus and are
// compared each cycle against an arithmetic reference model.
module tb_seq_shift_unit;
   import seq_shift_pkg::*;

   localparam int W  = 32;
   localparam int SW = 5;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [1:0]    op;
   logic [W-1:0]  din;
   logic [SW-1:0] shamt;
   logic          busy1, done1, busy4, done4;
   logic [W-1:0]  dout1, dout4;
   logic [1:0]    st1, st4;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   seq_shift_unit #(.WIDTH(W), .STEP(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op), .din(din), .shamt(shamt),
      .busy(busy1), .done(done1), .dout(dout1), .state_dbg(st1)
   );

   seq_shift_unit #(.WIDTH(W), .STEP(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op), .din(din), .shamt(shamt),
      .busy(busy4), .done(done4), .dout(dout4), .state_dbg(st4)
   );

   task automatic check_val(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   function automatic int eff_amount(input logic [1:0] o, input int s);
`ifdef SEQ_SHIFT_ROTATE_EN
      return s;
`else
      return (o == 2'b11) ? 0 : s;
`endif
   endfunction

   function automatic logic [W-1:0] model(input logic [1:0] o, input logic [W-1:0] d, input int s);
      int e;
      e = eff_amount(o, s);
      case (o)
         2'b00:   return d << e;
         2'b01:   return d >> e;
         2'b10:   return d[W-1] ? ~((~d) >> e) : (d >> e);
         default: return (e == 0) ? d : ((d >> e) | (d << (W - e)));
      endcase
   endfunction

   function automatic int model_lat(input logic [1:0] o, input int s, input int step);
      return (eff_amount(o, s) + step - 1) / step + 1;
   endfunction

   task automatic check_cycle(input string name, input int c, input int lat, input logic [W-1:0] exp,
                              input logic dn, input logic bs, input logic [W-1:0] dt);
      check_val({name, "_done"}, W'(dn), W'(c == lat));
      check_val({name, "_busy"}, W'(bs), W'(c <= lat));
      if (c >= lat) check_val({name, "_dout"}, dt, exp);
   endtask

   // Called at a negedge with both units idle; optionally re-asserts start while busy.
   task automatic run_op(input logic [1:0] o, input logic [W-1:0] d, input logic [SW-1:0] s, input bit poke);
      logic [W-1:0] exp;
      int l1, l4, lmin, lmax;
      exp  = model(o, d, int'(s));
      l1   = model_lat(o, int'(s), 1);
      l4   = model_lat(o, int'(s), 4);
      lmin = (l1 < l4) ? l1 : l4;
      lmax = (l1 > l4) ? l1 : l4;
      op = o; din = d; shamt = s; start = 1'b1;
      for (int c = 1; c <= lmax + 1; c++) begin
         @(negedge clk);
         check_cycle("s1", c, l1, exp, done1, busy1, dout1);
         check_cycle("s4", c, l4, exp, done4, busy4, dout4);
         if (poke && c <= lmin) begin
            start = 1'b1; op = OP_SLL; shamt = 5'd5; din = $urandom;
         end else begin
            start = 1'b0; op = 2'($urandom); shamt = 5'($urandom); din = $urandom;
         end
      end
      start = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; op = '0; din = '0; shamt = '0;
      #12;
      check_val("rst_busy1", W'(busy1), '0);
      check_val("rst_done1", W'(done1), '0);
      check_val("rst_dout1", dout1, '0);
      check_val("rst_state1", W'(st1), W'(ST_IDLE));
      check_val("rst_busy4", W'(busy4), '0);
      check_val("rst_dout4", dout4, '0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op(OP_SLL, 32'h0000_0001, 5'd2,  1'b0);
      run_op(OP_SRA, 32'h8000_0000, 5'd31, 1'b0);
      run_op(OP_SRL, 32'hF000_000F, 5'd0,  1'b0);
      run_op(OP_SRL, 32'h1234_5678, 5'd9,  1'b1);
      run_op(OP_ROR, 32'h0000_0001, 5'd1,  1'b0);
      run_op(OP_SRA, 32'h7FFF_0000, 5'd31, 1'b1);

      // Abort mid-shift: outputs must clear asynchronously and no done may follow.
      op = OP_SRL; din = 32'hDEAD_BEEF; shamt = 5'd20; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_val("abort_busy1", W'(busy1), '0);
      check_val("abort_done1", W'(done1), '0);
      check_val("abort_dout1", dout1, '0);
      check_val("abort_busy4", W'(busy4), '0);
      check_val("abort_dout4", dout4, '0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         check_val("abort_nodone1", W'(done1), '0);
         check_val("abort_nodone4", W'(done4), '0);
      end

      for (int n = 0; n < 60; n++)
         run_op(2'($urandom_range(3, 0)), $urandom, 5'($urandom_range(31, 0)), 1'($urandom_range(1, 0)));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
